// File: rtl/col2im_sched_if.sv
// Handshake bundle between the col2im sequencer, the patch buffer,
// the col2im datapath and the image consumer.
interface col2im_sched_if #(
  parameter int RW = 5,
  parameter int CW = 5
);
  logic          patch_valid;
  logic          patch_ready;
  logic          dp_input_ready;
  logic [RW-1:0] dp_i;
  logic [CW-1:0] dp_j;
  logic [1:0]    dp_state;
  logic          dp_output_taken;
  logic          img_valid;
  logic          img_ready;

  modport master (
    input  patch_valid, dp_state, img_ready,
    output patch_ready, dp_input_ready, dp_i, dp_j, dp_output_taken, img_valid
  );

  modport slave (
    output patch_valid, dp_state, img_ready,
    input  patch_ready, dp_input_ready, dp_i, dp_j, dp_output_taken, img_valid
  );
endinterface

// File: rtl/col2im_sched.sv
// col2im patch sequencer: fetch patch, arm datapath, wait for result,
// release it, walk patches row-major, then hand the image downstream.
module col2im_sched #(
  parameter int h       = 512,
  parameter int w       = 512,
  parameter int k       = 16,
  parameter int h_width = $clog2(h),
  parameter int w_width = $clog2(w),
  parameter int k_width = $clog2(k),
  parameter int TIMEOUT = 1024,
  parameter int TW      = $clog2(TIMEOUT+1),
  localparam int RW     = h_width - k_width,
  localparam int CW     = w_width - k_width,
  localparam int PCW    = h_width + w_width - 2*k_width + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [RW-1:0]   cfg_rows,
  input  logic [CW-1:0]   cfg_cols,
  col2im_sched_if.master  bus,
  output logic            busy,
  output logic            frame_done,
  output logic            err,
  output logic [PCW-1:0]  patch_count,
  output logic [2:0]      fsm
);
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    ARM     = 3'd2,
    WAIT    = 3'd3,
    RELEASE = 3'd4,
    OUT     = 3'd5
  } state_t;

  state_t         state, state_n;
  logic [RW-1:0]  row, row_n, lim_r, lim_r_n;
  logic [CW-1:0]  col, col_n, lim_c, lim_c_n;
  logic [PCW-1:0] cnt_n;
  logic [TW-1:0]  wd, wd_n;
  logic           err_n, fd_q, fd_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      row         <= '0;
      col         <= '0;
      lim_r       <= '0;
      lim_c       <= '0;
      patch_count <= '0;
      wd          <= '0;
      err         <= 1'b0;
      fd_q        <= 1'b0;
    end else begin
      state       <= state_n;
      row         <= row_n;
      col         <= col_n;
      lim_r       <= lim_r_n;
      lim_c       <= lim_c_n;
      patch_count <= cnt_n;
      wd          <= wd_n;
      err         <= err_n;
      fd_q        <= fd_n;
    end
  end

  always_comb begin
    state_n = state;
    row_n   = row;
    col_n   = col;
    lim_r_n = lim_r;
    lim_c_n = lim_c;
    cnt_n   = patch_count;
    wd_n    = wd;
    err_n   = err;
    fd_n    = 1'b0;
    case (state)
      IDLE: if (start) begin
        lim_r_n = cfg_rows;
        lim_c_n = cfg_cols;
        row_n   = '0;
        col_n   = '0;
        cnt_n   = '0;
        err_n   = 1'b0;
        state_n = FETCH;
      end
      FETCH: if (bus.patch_valid) begin
        cnt_n   = patch_count + 1'b1;
        state_n = ARM;
      end
      ARM: begin
        wd_n    = '0;
        state_n = WAIT;
      end
      WAIT: begin
        // A result on the same cycle the watchdog expires still wins.
        if (bus.dp_state == 2'b10) state_n = RELEASE;
        else begin
          wd_n = wd + 1'b1;
          if (wd_n == TW'(TIMEOUT)) begin
            err_n   = 1'b1;
            state_n = IDLE;
          end
        end
      end
      RELEASE: begin
        if (row == lim_r && col == lim_c) state_n = OUT;
        else begin
          state_n = FETCH;
          if (col == lim_c) begin
            col_n = '0;
            row_n = row + 1'b1;
          end else col_n = col + 1'b1;
        end
      end
      OUT: if (bus.img_ready) begin
        fd_n    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.patch_ready     = (state == FETCH);
  assign bus.dp_input_ready  = (state == ARM);
  assign bus.dp_output_taken = (state == RELEASE);
  assign bus.img_valid       = (state == OUT);
  assign bus.dp_i            = row;
  assign bus.dp_j            = col;
  assign busy                = (state != IDLE);
  assign frame_done          = fd_q;
  assign fsm                 = state;
endmodule

// File: tb/tb_col2im_sched.sv
// Directed bench for col2im_sched: datapath/upstream/downstream models
// plus one task per scenario with hand-computed expectations.
module tb_col2im_sched;
  localparam int H = 16, W = 16, K = 4, TO = 8;
  localparam int RW = 2, CW = 2, PCW = 5;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [RW-1:0]  cfg_rows = '0;
  logic [CW-1:0]  cfg_cols = '0;
  logic           busy, frame_done, err;
  logic [PCW-1:0] patch_count;
  logic [2:0]     fsm;

  int checks = 0, failures = 0;

  col2im_sched_if #(.RW(RW), .CW(CW)) bus();

  col2im_sched #(.h(H), .w(W), .k(K), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .bus(bus),
    .busy(busy), .frame_done(frame_done), .err(err),
    .patch_count(patch_count), .fsm(fsm)
  );

  always #5 clk = ~clk;

  // datapath model: result appears on the lat-th WAIT cycle unless stuck
  int            lat = 2;
  bit            stuck_en = 1'b0;
  logic [RW-1:0] stuck_i = '0;
  logic [CW-1:0] stuck_j = '0;
  bit            stuck_now;
  int            dp_cnt;
  always @(posedge clk) begin
    if (reset) begin
      bus.dp_state <= 2'b00;
      dp_cnt       <= 0;
      stuck_now    <= 1'b0;
    end else if (bus.dp_input_ready) begin
      dp_cnt    <= 1;
      stuck_now <= stuck_en && bus.dp_i == stuck_i && bus.dp_j == stuck_j;
      bus.dp_state <= (lat == 1 && !(stuck_en && bus.dp_i == stuck_i && bus.dp_j == stuck_j))
                      ? 2'b10 : 2'b01;
    end else if (bus.dp_output_taken) begin
      bus.dp_state <= 2'b00;
    end else if (bus.dp_state == 2'b01 && !stuck_now) begin
      dp_cnt <= dp_cnt + 1;
      if (dp_cnt + 1 >= lat) bus.dp_state <= 2'b10;
    end
  end

  // upstream holds patch_valid low for pv_gap FETCH cycles; downstream
  // holds img_ready low for ir_gap OUT cycles
  int pv_gap = 0, ir_gap = 0, gap, igap;
  assign bus.patch_valid = (gap >= pv_gap);
  assign bus.img_ready   = (igap >= ir_gap);
  always @(posedge clk) begin
    if (reset) begin
      gap  <= 0;
      igap <= 0;
    end else begin
      if (bus.patch_ready) gap <= bus.patch_valid ? 0 : gap + 1;
      if (bus.img_valid)   igap <= bus.img_ready ? 0 : igap + 1;
    end
  end

  // monitor
  int                  cyc = 0, fd_cnt = 0, iv_cnt = 0;
  logic [RW+CW-1:0]    coords[$];
  int                  arm_cyc[$];
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.dp_input_ready) begin
      coords.push_back({bus.dp_i, bus.dp_j});
      arm_cyc.push_back(cyc);
    end
    if (frame_done)    fd_cnt <= fd_cnt + 1;
    if (bus.img_valid) iv_cnt <= iv_cnt + 1;
  end

  task automatic do_start(input logic [RW-1:0] r, input logic [CW-1:0] c);
    @(negedge clk);
    cfg_rows = r; cfg_cols = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(output bit to);
    int n = 0;
    while (fsm != 3'd0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    to = (fsm != 3'd0);
    @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (fsm !== 3'd0) begin failures++; $display("FAIL reset_fsm got=%0d exp=0", fsm); end
    checks++;
    if (patch_count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", patch_count); end
    checks++;
    if ({busy, frame_done, err, bus.patch_ready, bus.dp_input_ready, bus.dp_output_taken,
         bus.img_valid, bus.dp_i, bus.dp_j} !== '0)
      begin failures++; $display("FAIL reset_outputs got=%b exp=0", {busy, frame_done, err,
        bus.patch_ready, bus.dp_input_ready, bus.dp_output_taken, bus.img_valid, bus.dp_i, bus.dp_j}); end
  endtask

  task automatic test_basic;
    logic [3:0] exp [4] = '{4'b0000, 4'b0001, 4'b0100, 4'b0101};
    int i0 = coords.size(), fd0 = fd_cnt, iv0 = iv_cnt;
    bit to;
    lat = 2; pv_gap = 0; ir_gap = 0;
    do_start(2'd1, 2'd1);
    checks++;
    if ({busy, bus.patch_ready} !== 2'b11) begin failures++; $display("FAIL start_busy_ready got=%b exp=11", {busy, bus.patch_ready}); end
    wait_idle(to);
    checks++;
    if (to) begin failures++; $display("FAIL basic_timeout fsm=%0d exp=0", fsm); end
    checks++;
    if (coords.size() - i0 != 4) begin failures++; $display("FAIL basic_npatch got=%0d exp=4", coords.size() - i0); end
    else for (int i = 0; i < 4; i++) begin
      checks++;
      if (coords[i0+i] !== exp[i]) begin failures++; $display("FAIL basic_coord%0d got=%b exp=%b", i, coords[i0+i], exp[i]); end
      if (i > 0) begin
        checks++;
        if (arm_cyc[i0+i] - arm_cyc[i0+i-1] != 5) begin failures++;
          $display("FAIL basic_spacing%0d got=%0d exp=5", i, arm_cyc[i0+i] - arm_cyc[i0+i-1]); end
      end
    end
    checks++;
    if (iv_cnt - iv0 != 1) begin failures++; $display("FAIL basic_img_valid got=%0d exp=1", iv_cnt - iv0); end
    checks++;
    if (fd_cnt - fd0 != 1) begin failures++; $display("FAIL basic_frame_done got=%0d exp=1", fd_cnt - fd0); end
    checks++;
    if (patch_count !== 5'd4) begin failures++; $display("FAIL basic_count got=%0d exp=4", patch_count); end
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL basic_err got=%b exp=0", err); end
  endtask

  task automatic test_backpressure;
    int i0 = coords.size(), fd0 = fd_cnt, iv0 = iv_cnt;
    bit to;
    pv_gap = 3; ir_gap = 5;
    do_start(2'd0, 2'd1);
    wait_idle(to);
    checks++;
    if (to) begin failures++; $display("FAIL bp_timeout fsm=%0d exp=0", fsm); end
    checks++;
    if (coords.size() - i0 != 2) begin failures++; $display("FAIL bp_npatch got=%0d exp=2", coords.size() - i0); end
    else begin
      checks++;
      if ({coords[i0], coords[i0+1]} !== 8'b0000_0001) begin failures++;
        $display("FAIL bp_coords got=%b exp=00000001", {coords[i0], coords[i0+1]}); end
      checks++;
      if (arm_cyc[i0+1] - arm_cyc[i0] != 8) begin failures++;
        $display("FAIL bp_spacing got=%0d exp=8", arm_cyc[i0+1] - arm_cyc[i0]); end
    end
    checks++;
    if (iv_cnt - iv0 != 6) begin failures++; $display("FAIL bp_img_valid got=%0d exp=6", iv_cnt - iv0); end
    checks++;
    if (fd_cnt - fd0 != 1) begin failures++; $display("FAIL bp_frame_done got=%0d exp=1", fd_cnt - fd0); end
    checks++;
    if (patch_count !== 5'd2) begin failures++; $display("FAIL bp_count got=%0d exp=2", patch_count); end
    pv_gap = 0; ir_gap = 0;
  endtask

  task automatic test_watchdog;
    int fd0 = fd_cnt, iv0 = iv_cnt, waits = 0, n = 0;
    bit to;
    stuck_en = 1'b1; stuck_i = 2'd0; stuck_j = 2'd1;
    do_start(2'd1, 2'd1);
    while (fsm != 3'd0 && n < 400) begin
      @(negedge clk);
      n++;
      if (bus.dp_input_ready) waits = 0;
      if (fsm == 3'd3) waits++;
    end
    checks++;
    if (fsm !== 3'd0) begin failures++; $display("FAIL wd_idle fsm=%0d exp=0", fsm); end
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL wd_err got=%b exp=1", err); end
    checks++;
    if (waits != TO) begin failures++; $display("FAIL wd_wait_cycles got=%0d exp=%0d", waits, TO); end
    @(negedge clk);
    checks++;
    if (fd_cnt - fd0 != 0 || iv_cnt - iv0 != 0) begin failures++;
      $display("FAIL wd_no_done frame_done=%0d img_valid=%0d exp=0", fd_cnt - fd0, iv_cnt - iv0); end
    checks++;
    if (patch_count !== 5'd2) begin failures++; $display("FAIL wd_count got=%0d exp=2", patch_count); end
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL wd_err_sticky got=%b exp=1", err); end
    stuck_en = 1'b0;
    do_start(2'd0, 2'd0);
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL wd_err_clear got=%b exp=0", err); end
    wait_idle(to);
    checks++;
    if (to) begin failures++; $display("FAIL wd_recover_timeout fsm=%0d exp=0", fsm); end
  endtask

  task automatic test_reset_mid;
    int i0 = coords.size(), fd0 = fd_cnt, n = 0;
    bit to;
    do_start(2'd3, 2'd3);
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (coords.size() - i0 >= 6 && fsm == 3'd3) break;
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (fsm !== 3'd0 || patch_count !== '0) begin failures++;
      $display("FAIL rst_mid_state fsm=%0d count=%0d exp=0/0", fsm, patch_count); end
    checks++;
    if ({busy, frame_done, err, bus.patch_ready, bus.dp_input_ready, bus.dp_output_taken,
         bus.img_valid, bus.dp_i, bus.dp_j} !== '0)
      begin failures++; $display("FAIL rst_mid_outputs got=%b exp=0", {busy, frame_done, err,
        bus.patch_ready, bus.dp_input_ready, bus.dp_output_taken, bus.img_valid, bus.dp_i, bus.dp_j}); end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (fd_cnt - fd0 != 0) begin failures++; $display("FAIL rst_mid_no_done got=%0d exp=0", fd_cnt - fd0); end
    i0 = coords.size();
    do_start(2'd0, 2'd1);
    wait_idle(to);
    checks++;
    if (to || coords.size() - i0 != 2) begin failures++;
      $display("FAIL rst_restart_npatch got=%0d exp=2", coords.size() - i0); end
    else begin
      checks++;
      if (coords[i0] !== 4'b0000) begin failures++; $display("FAIL rst_restart_first got=%b exp=0000", coords[i0]); end
    end
  endtask

  task automatic test_ignored;
    logic [3:0] exp [4] = '{4'b0000, 4'b0001, 4'b0100, 4'b0101};
    int i0 = coords.size(), fd0 = fd_cnt, n = 0;
    bit sw = 0, so = 0;
    ir_gap = 3;
    do_start(2'd1, 2'd1);
    cfg_rows = 2'd0; cfg_cols = 2'd0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (fsm == 3'd0) break;
      if (fsm == 3'd3 && !sw) begin start = 1'b1; sw = 1; end
      else if (fsm == 3'd5 && !so) begin start = 1'b1; so = 1; end
    end
    @(negedge clk);
    checks++;
    if (fsm !== 3'd0) begin failures++; $display("FAIL ign_stays_idle fsm=%0d exp=0", fsm); end
    checks++;
    if (fd_cnt - fd0 != 1) begin failures++; $display("FAIL ign_frame_done got=%0d exp=1", fd_cnt - fd0); end
    checks++;
    if (coords.size() - i0 != 4) begin failures++; $display("FAIL ign_npatch got=%0d exp=4", coords.size() - i0); end
    else begin
      checks++;
      if ({coords[i0], coords[i0+1], coords[i0+2], coords[i0+3]} !== {exp[0], exp[1], exp[2], exp[3]})
        begin failures++; $display("FAIL ign_coords got=%b exp=%b",
          {coords[i0], coords[i0+1], coords[i0+2], coords[i0+3]}, {exp[0], exp[1], exp[2], exp[3]}); end
    end
    checks++;
    if (patch_count !== 5'd4) begin failures++; $display("FAIL ign_count got=%0d exp=4", patch_count); end
    ir_gap = 0;
  endtask

  task automatic test_back_to_back;
    int i0 = coords.size(), fd0 = fd_cnt, n = 0;
    bit to;
    do_start(2'd0, 2'd1);
    while (!frame_done && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (frame_done !== 1'b1) begin failures++; $display("FAIL b2b_first_done got=%b exp=1", frame_done); end
    cfg_rows = 2'd0; cfg_cols = 2'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (fsm !== 3'd1) begin failures++; $display("FAIL b2b_accept fsm=%0d exp=1", fsm); end
    wait_idle(to);
    checks++;
    if (to) begin failures++; $display("FAIL b2b_timeout fsm=%0d exp=0", fsm); end
    checks++;
    if (fd_cnt - fd0 != 2) begin failures++; $display("FAIL b2b_frame_done got=%0d exp=2", fd_cnt - fd0); end
    checks++;
    if (coords.size() - i0 != 3) begin failures++; $display("FAIL b2b_npatch got=%0d exp=3", coords.size() - i0); end
    else begin
      checks++;
      if (coords[i0+2] !== 4'b0000) begin failures++; $display("FAIL b2b_single_coord got=%b exp=0000", coords[i0+2]); end
    end
    checks++;
    if (patch_count !== 5'd1) begin failures++; $display("FAIL b2b_count got=%0d exp=1", patch_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_watchdog();
    test_reset_mid();
    test_ignored();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/col2im_sched.md
# col2im_sched

Sequencer for the col2im scatter datapath in the GEMM path. Pulls patches one at a time from the GEMM result buffer and drives the col2im transaction handshake (input_ready / state / output_taken) with row-major patch coordinates. Presents the completed image to the downstream consumer. Single-cycle decisions throughout, with a watchdog on each datapath transaction.

## Interface

- Clocking and reset: one clock; reset is synchronous and active-high.

Parameters:
- `h`, default 512: image height.
- `w`, default 512: image width.
- `k`, default 16: patch edge.
- `h_width`, default `$clog2(h)`: height index width.
- `w_width`, default `$clog2(w)`: width index width.
- `k_width`, default `$clog2(k)`: patch index width.
- `TIMEOUT`, default 1024: maximum number of WAIT cycles per patch.
- `TW`, default `$clog2(TIMEOUT+1)`: width of the watchdog counter.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a frame; honoured only in IDLE.
- `cfg_rows`  in  h_width-k_width  last patch row index (patch rows = cfg_rows+1).
- `cfg_cols`  in  w_width-k_width  last patch column index.
- `patch_valid`  in  1  upstream patch available.
- `patch_ready`  out  1  sched accepts a patch.
- `dp_input_ready`  out  1  start a col2im transaction.
- `dp_i`  out  h_width-k_width  patch row of the current transaction.
- `dp_j`  out  w_width-k_width  patch column of the current transaction.
- `dp_state`  in  2  col2im state: 00 idle, 01 busy, 10 result held.
- `dp_output_taken`  out  1  releases col2im from state 10.
- `img_valid`  out  1  frame image complete.
- `img_ready`  in  1  downstream takes the image.
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse at the end of a frame.
- `err`  out  1  sticky watchdog error.
- `patch_count`  out  h_width+w_width-2*k_width+1  number of patches accepted in the current frame.
- `fsm`  out  3  current state encoding, for debug.

## Operation

State encodings: IDLE=0, FETCH=1, ARM=2, WAIT=3, RELEASE=4, OUT=5.

- IDLE:
  - On `start`: latch `cfg_rows` and `cfg_cols`; clear row, col, `patch_count` and `err`; go to FETCH.
- FETCH:
  - `patch_ready`=1.
  - On `patch_valid` && `patch_ready`: `patch_count`++; go to ARM.
- ARM:
  - `dp_input_ready`=1 for exactly one cycle.
  - Clear the watchdog; go to WAIT.
- WAIT:
  - When `dp_state`==2'b10, go to RELEASE.
  - Otherwise increment the watchdog.
  - If the watchdog reaches TIMEOUT: set `err`=1 and go to IDLE. No `frame_done`, no `img_valid`.
- RELEASE:
  - `dp_output_taken`=1 for exactly one cycle.
  - If (row==cfg_rows && col==cfg_cols), go to OUT.
  - Otherwise advance row-major and go to FETCH. col==cfg_cols wraps col to 0 and increments row; else col++.
- OUT:
  - `img_valid`=1, held until `img_ready`.
  - On the handshake: `frame_done`=1 for one cycle, go to IDLE.
- `dp_i`/`dp_j` are driven from the registered row/col and are stable from ARM through RELEASE.
- `start` outside IDLE is ignored. `cfg_*` is sampled only on accepted starts.
- `patch_valid` is ignored outside FETCH; `patch_ready`=0 there.
- `dp_state` is ignored outside WAIT.
- Counters never wrap within a frame: the maximum count is (cfg_rows+1)*(cfg_cols+1), and `patch_count` has one spare bit.

## Timing

- Reset values: `fsm`=IDLE; row, col and `patch_count` = 0. All other outputs are 0, including `err`, `patch_ready`, `dp_input_ready`, `dp_output_taken`, `img_valid`, `busy`, `frame_done`, `dp_i` and `dp_j`.
- All outputs are Moore outputs decoded from registered state. No combinational path from inputs to outputs.
- `start` at edge N: `busy`=1 and `patch_ready`=1 from cycle N+1.
- Per-patch minimum is 4 cycles: FETCH accept, ARM, WAIT (`dp_state`=10 on the first WAIT cycle), RELEASE.
- `img_valid` rises the cycle after the last RELEASE.
- `frame_done` coincides with the cycle after the `img_valid`&&`img_ready` edge; IDLE is entered at the same edge.
- A new `start` is accepted in the cycle `frame_done` is high.
- Reset asserted mid-frame: the next cycle is IDLE with all outputs 0. No `frame_done`; the partial frame is discarded.
- Watchdog: `err` rises on the cycle IDLE is entered, TIMEOUT cycles after ARM with no 10 observed.
- `err` clears only on the next accepted `start` or on reset.

## Test plan

- Basic 2x2 frame:
  - Stimulus: `cfg_rows`=1, `cfg_cols`=1; `patch_valid` tied 1; datapath model returns 10 on the 2nd WAIT cycle; `img_ready`=1.
  - Required: (`dp_i`,`dp_j`) sequence (0,0),(0,1),(1,0),(1,1); 5 cycles per patch; `img_valid` 1 cycle; one `frame_done`; `patch_count`=4.
- Backpressure:
  - Stimulus: `patch_valid` low for 3 cycles before each patch; `img_ready` low for 5 cycles in OUT.
  - Required: FETCH waits; `img_valid` held 6 cycles; no duplicated coordinates.
- Watchdog:
  - Stimulus: TIMEOUT=8; `dp_state` stuck at 01 on patch (0,1).
  - Required: `err`=1 eight cycles after ARM, `fsm`=IDLE, no `frame_done`.
  - Then: next `start` clears `err`.
- Reset mid-frame:
  - Stimulus: `cfg_rows`=`cfg_cols`=3; reset during WAIT of patch 6.
  - Required: all outputs 0 the next cycle, `patch_count`=0.
  - Then: a fresh start restarts at (0,0).
- Ignored inputs:
  - Stimulus: `start` pulses during WAIT and OUT; changes to `cfg_rows`/`cfg_cols` mid-frame.
  - Required: the frame completes with its originally latched geometry.
- Back-to-back frames and single patch:
  - Stimulus: `start` asserted in the `frame_done` cycle with `cfg_rows`=`cfg_cols`=0.
  - Required: the second frame runs exactly one patch at (0,0); `frame_done` ×2.
